// File: rtl/reel_spin_ctrl.sv
// Slot-machine reel sequencer: steps N reels of 2-bit symbol selects at a divided
// tick rate, then freezes them one after another with a staggered, optionally random, stop tick.
module reel_spin_ctrl #(
  parameter int N_REELS       = 3,
  parameter int TICK_DIV      = 2_500_000,
  parameter int SPIN_TICKS    = 20,
  parameter int STAGGER_TICKS = 8,
  parameter int RANDOM        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [2*N_REELS-1:0]   rot_state,
  output logic                   busy,
  output logic                   done,
  output logic                   match
);

  localparam int CW = $clog2(SPIN_TICKS + (N_REELS - 1) * STAGGER_TICKS + 4);
  localparam int DW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic [15:0]          lfsr_q;
  logic [DW-1:0]        div_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [CW-1:0]        stop_q [N_REELS];
  logic [N_REELS-1:0]   stopped_q, stopped_d;
  logic [2*N_REELS-1:0] rot_q, rot_d;
  logic                 match_q;

  logic                 accept;
  logic                 tick;
  logic [CW-1:0]        tick_cnt_inc;
  logic                 all_equal;

  assign accept       = (state_q == IDLE) && start && !start_q;
  assign tick         = (state_q == SPIN) && (div_q == DW'(TICK_DIV - 1));
  assign tick_cnt_inc = tick_cnt_q + CW'(1);

  // Reel stepping and stop detection for the current cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rot_d     = rot_q;
    stopped_d = stopped_q;
    all_equal = 1'b1;
    for (int i = 0; i < N_REELS; i++) begin
      if (tick && !stopped_q[i]) begin
        rot_d[2*i +: 2] = rot_q[2*i +: 2] + 2'd1;
        if (tick_cnt_inc == stop_q[i]) begin
          stopped_d[i] = 1'b1;
        end
      end
    end
    for (int i = 1; i < N_REELS; i++) begin
      if (rot_d[2*i +: 2] != rot_d[1:0]) begin
        all_equal = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SPIN;
      SPIN:    if (&stopped_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      lfsr_q     <= 16'hACE1;
      div_q      <= '0;
      tick_cnt_q <= '0;
      stopped_q  <= '0;
      rot_q      <= '0;
      match_q    <= 1'b0;
      // NOTE: the stop table is a handful of flops, so it is reset like any other state.
      for (int i = 0; i < N_REELS; i++) begin
        stop_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      start_q <= start;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      if (state_q == SPIN) begin
        div_q <= tick ? '0 : div_q + DW'(1);
      end else begin
        div_q <= '0;
      end

      if (accept) begin
        tick_cnt_q <= '0;
        stopped_q  <= '0;
        match_q    <= 1'b0;
        for (int i = 0; i < N_REELS; i++) begin
          stop_q[i] <= CW'(SPIN_TICKS + i * STAGGER_TICKS
                           + ((RANDOM != 0) ? int'(lfsr_q[2*i +: 2]) : 0));
        end
      end else begin
        if (tick) begin
          tick_cnt_q <= tick_cnt_inc;
        end
        stopped_q <= stopped_d;
        rot_q     <= rot_d;
        // Reels hold their final values on the edge entering DONE.
        if (state_q == SPIN && state_d == DONE) begin
          match_q <= all_equal;
        end
      end
    end
  end

  // Outputs decode directly from flops.
  always_comb begin
    rot_state = rot_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    match     = match_q;
  end

endmodule
